// File: rtl/zz_pkg.sv
// -----------------------------------------------------------------------------
// zz_pkg
// Shared constants for the coefficient block unpacker:
//   BLK          - entries in one 8x8 block
//   IDX_W        - width of a raster index (0..63)
//   bank_state_e - per-bank fill state
//   ZIGZAG       - default JPEG zigzag order; ZIGZAG[k] is the raster index of
//                  the k-th coefficient in transmit order, handy for building
//                  the pattern input
// -----------------------------------------------------------------------------
package zz_pkg;

    localparam int BLK   = 64;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    localparam int ZIGZAG [BLK] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/coeff_bank.sv
// -----------------------------------------------------------------------------
// coeff_bank
// One 64-entry block buffer with a per-entry written mask. Entries that have
// not been written since the last clear read back as zero, so untransmitted
// positions are zero-filled without touching the value registers.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears the mask only)
//   we_i       - write enable for entry idx_i
//   idx_i      - raster index written
//   data_i     - dequantized value written
//   clr_i      - clear the written mask (block consumed)
//   rd_o       - masked block, entry p at [p*OUT_W +: OUT_W]
// -----------------------------------------------------------------------------
module coeff_bank
    import zz_pkg::*;
#(
    parameter int OUT_W = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [OUT_W-1:0]       data_i,
    input  logic                   clr_i,
    output logic [BLK*OUT_W-1:0]   rd_o
);

    logic [OUT_W-1:0] val_q [BLK];
    logic [BLK-1:0]   mask_q;
    logic [BLK-1:0]   mask_d;

    // Value storage carries no reset; the mask alone decides visibility.
    always_ff @(posedge clk) begin
        if (we_i) begin
            val_q[idx_i] <= data_i;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (clr_i) begin
            mask_d = '0;
        end
        if (we_i) begin
            mask_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_comb begin
        rd_o = '0;
        for (int p = 0; p < BLK; p++) begin
            rd_o[p*OUT_W +: OUT_W] = mask_q[p] ? val_q[p] : '0;
        end
    end

endmodule

// File: rtl/coeff_block_unpacker.sv
// -----------------------------------------------------------------------------
// coeff_block_unpacker
// Takes zigzag-ordered quantized coefficients one per cycle, dequantizes each
// by the Q entry of its raster position and scatters it into one of two
// ping-pong block banks. A completed bank is presented as a full raster block
// until the consumer accepts it, while the other bank keeps filling.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   pattern             - N_COEF x 6 bit zigzag table (k-th entry = raster idx)
//   qtab                - 64 x Q_W quantizer table in raster order
//   s_valid/s_ready     - coefficient input handshake
//   s_data, s_last      - signed coefficient, end-of-block marker
//   m_valid/m_ready     - block output handshake
//   m_block             - 64 x OUT_W dequantized block, raster order
//   err_frame           - one-cycle pulse when s_last and the count disagree
// -----------------------------------------------------------------------------
module coeff_block_unpacker
    import zz_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int Q_W    = 8,
    parameter int N_COEF = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_COEF*IDX_W-1:0]              pattern,
    input  logic [BLK*Q_W-1:0]                   qtab,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [COEF_W-1:0]                    s_data,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [BLK*(COEF_W+Q_W+1)-1:0]        m_block,
    output logic                                 err_frame
);

    localparam int OUT_W = COEF_W + Q_W + 1;
    localparam int K_W   = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_COEF - 1);

    // Full-precision signed product; the quantizer entry is zero-extended so
    // it is always treated as non-negative.
    function automatic logic signed [OUT_W-1:0] dequant(
        input logic signed [COEF_W-1:0] c,
        input logic        [Q_W-1:0]    q
    );
        logic signed [OUT_W-1:0] a;
        logic signed [OUT_W-1:0] b;
        a = {{(Q_W+1){c[COEF_W-1]}}, c};
        b = {{COEF_W{1'b0}}, q};
        return a * b;
    endfunction

    bank_state_e        state_q [2];
    bank_state_e        state_d [2];
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               err_q, err_d;

    logic               accept;
    logic               hs;
    logic               at_last_k;
    logic               close;
    logic [IDX_W-1:0]   p_idx;
    logic [Q_W-1:0]     q_sel;
    logic [OUT_W-1:0]   prod;
    logic [BLK*OUT_W-1:0] rd_vec [2];

    assign s_ready   = (state_q[wr_bank_q] != FULL);
    assign m_valid   = (state_q[rd_bank_q] == FULL);
    assign accept    = s_valid && s_ready;
    assign hs        = m_valid && m_ready;
    assign at_last_k = (k_q == K_LAST);
    assign close     = accept && (at_last_k || s_last);

    // Table lookups: raster position of the k-th coefficient, then its Q entry.
    always_comb begin
        p_idx = '0;
        for (int i = 0; i < N_COEF; i++) begin
            if (k_q == K_W'(i)) begin
                p_idx = pattern[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        q_sel = '0;
        for (int i = 0; i < BLK; i++) begin
            if (p_idx == IDX_W'(i)) begin
                q_sel = qtab[i*Q_W +: Q_W];
            end
        end
    end

    assign prod = dequant(s_data, q_sel);

    // The bank being released is always FULL and the bank being written never
    // is, so a release and a write in the same cycle hit different banks.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (hs && (rd_bank_q == 1'(b))) begin
                state_d[b] = EMPTY;
            end
            if (accept && (wr_bank_q == 1'(b))) begin
                state_d[b] = close ? FULL : FILLING;
            end
        end
    end

    always_comb begin
        wr_bank_d = close ? ~wr_bank_q : wr_bank_q;
        rd_bank_d = hs    ? ~rd_bank_q : rd_bank_q;
        k_d       = k_q;
        if (close) begin
            k_d = '0;
        end else if (accept) begin
            k_d = k_q + 1'b1;
        end
        // Early s_last, or a full count reached without s_last.
        err_d = accept && (s_last != at_last_k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            k_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            k_q        <= k_d;
            err_q      <= err_d;
        end
    end

    assign err_frame = err_q;

    coeff_bank #(.OUT_W(OUT_W)) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && !wr_bank_q),
        .idx_i  (p_idx),
        .data_i (prod),
        .clr_i  (hs && !rd_bank_q),
        .rd_o   (rd_vec[0])
    );

    coeff_bank #(.OUT_W(OUT_W)) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept && wr_bank_q),
        .idx_i  (p_idx),
        .data_i (prod),
        .clr_i  (hs && rd_bank_q),
        .rd_o   (rd_vec[1])
    );

    assign m_block = rd_vec[rd_bank_q];

endmodule
